pulse_burst_scheduler: RTL and testbench
========================================

// Module: pulse_burst_scheduler
// PURPOSE
//  Shares one serial pulse output between NREQ requesters, replacing free-running pattern pulsers.
//  Each requester asks for a burst: a PAT_W-bit pattern sent LSB first, each bit held DIV clocks.
//  Round-robin arbitration picks one burst at a time. A GAP of low cycles follows every burst.
//  Sits between clock-domain stimulus/test blocks and the single waveform line probed in VCD dumps.
// PARAMETERS
//  NREQ   2   number of requesters (>=2)
//  PAT_W  12  pattern width in bits
//  LEN_W  4   width of length field, >= clog2(PAT_W+1)
//  DIV    4   clocks each pattern bit is held (>=1)
//  GAP    2   idle-low clocks after each burst (>=1)
// PORTS
//  clock    in   1            single rising-edge clock
//  reset    in   1            asynchronous, active-low
//  req      in   NREQ         per-requester burst request, level; held until own done
//  pattern  in   NREQ*PAT_W   requester i pattern at [i*PAT_W +: PAT_W]
//  length   in   NREQ*LEN_W   requester i bit count at [i*LEN_W +: LEN_W]
//  grant    out  NREQ         one-hot, high from LOAD through end of GAP
//  done     out  NREQ         one-clock pulse to the served requester on burst completion
//  signal   out  1            serialized pulse line
//  busy     out  1            high in any state other than IDLE
// BEHAVIOUR
//  reset low (async): state=IDLE, grant=0, done=0, signal=0, busy=0, rr pointer=0, counters=0.
//  FSM IDLE -> LOAD -> RUN -> GAP -> IDLE:
//   IDLE: if |req, the arbiter picks a winner, starting the search at the rr pointer; next=LOAD.
//   LOAD (1 clk): capture pattern/length of winner; grant[winner]=1; signal=0.
//     If captured length==0, next=GAP (no bits sent); else next=RUN.
//   RUN: signal=shreg[0]; hold DIV clks, then shift right and increment bit count.
//     After len*DIV clks, next=GAP.
//   GAP: signal=0 for GAP clks; on exit grant->0, done[winner]=1 for one clk (in IDLE),
//     rr pointer = winner+1 mod NREQ.
//  length > PAT_W clamps to PAT_W. Pattern/length changes after LOAD are ignored.
//  Burst duration, LOAD entry to done: 1 + len*DIV + GAP clks.
//  First bit appears on signal 1 clk after grant rises.
//  req dropped mid-burst: burst still completes, done still pulses.
//  req still high in the done cycle: not rearbitrated that cycle. IDLE lasts >=1 clk between bursts.
//    The next pick starts at winner+1, so the other requesters go first.
//  Only one req high: it is re-served back-to-back (no starvation checks needed).
//  reset mid-burst: immediate return to IDLE values; no done is issued.
//  Outputs are registered; no combinational path from req to grant or signal.
// STRUCTURE
//  Shared package pulse_pkg: state encoding (IDLE=2'd0, LOAD=2'd1, RUN=2'd2, GAP=2'd3).
//    Also holds the default DIV/GAP constants.
//  Sub-module rr_arbiter #(NREQ): inputs req, ptr, enable; output one-hot gnt, combinational.
//  Top level holds the FSM, shift register, DIV divider counter, bit counter, GAP counter and rr pointer.
// TESTING
//  1 reset low at t=0, req=0 -> grant=0, done=0, signal=0, busy=0 throughout.
//  2 req=01, pattern0=12'b0000_0010_1101, length0=6, DIV=4, GAP=2 ->
//    grant=01 one clk after the req edge; signal=1,0,1,1,0,1 (4 clks each); done[0] after 27 clks.
//  3 req=11 held, equal lengths 3 -> grants alternate 01,10,01,10.
//    Each done pulses exactly once per burst; no back-to-back grant to the same requester.
//  4 length0=0 -> LOAD, GAP, done[0] after 1+0+2=3 clks; signal stays 0.
//  5 length0=15 (>PAT_W) -> exactly 12 bits sent (48 clks of RUN).
//  6 req0 dropped 5 clks into RUN -> burst completes, done[0] pulses.
//    Then reset low mid-burst -> all outputs 0 asynchronously, no done.

Source files
------------

// File: rtl/pulse_pkg.sv
// Shared definitions for the pulse burst scheduler: FSM encoding and default timing constants.
package pulse_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_GAP  = 2'd3
  } state_t;

  localparam int DIV_DEFAULT = 4;
  localparam int GAP_DEFAULT = 2;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first asserted req at or after ptr wins, one-hot result.
module rr_arbiter #(
  parameter int NREQ  = 2,
  parameter int PTR_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]  req,
  input  logic [PTR_W-1:0] ptr,
  input  logic             enable,
  output logic [NREQ-1:0]  gnt
);

  logic [PTR_W-1:0] idx;

  // Walk offsets from farthest to nearest so the nearest requester overwrites the rest.
  always_comb begin
    gnt = '0;
    idx = '0;
    if (enable) begin
      for (int i = NREQ - 1; i >= 0; i--) begin
        idx = PTR_W'((int'(ptr) + i) % NREQ);
        if (req[idx]) begin
          gnt      = '0;
          gnt[idx] = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/pulse_burst_scheduler.sv
// Shares one serial pulse line between NREQ requesters; each burst is LOAD, len*DIV clocks of
// pattern bits (LSB first), then GAP low clocks, with round-robin selection between bursts.
module pulse_burst_scheduler
  import pulse_pkg::*;
#(
  parameter int NREQ  = 2,
  parameter int PAT_W = 12,
  parameter int LEN_W = 4,
  parameter int DIV   = DIV_DEFAULT,
  parameter int GAP   = GAP_DEFAULT
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ*PAT_W-1:0]  pattern,
  input  logic [NREQ*LEN_W-1:0]  length,
  output logic [NREQ-1:0]        grant,
  output logic [NREQ-1:0]        done,
  output logic                   signal,
  output logic                   busy,
  output state_t                 fsm_state
);

  localparam int PTR_W = $clog2(NREQ);
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int GAP_W = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP - 1);
  localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(PAT_W);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NREQ - 1);

  state_t           state_q, state_d;
  logic [NREQ-1:0]  arb_gnt, grant_q, grant_d, done_q, done_d;
  logic [PTR_W-1:0] arb_idx, win_q, rr_ptr_q;
  logic [PAT_W-1:0] sel_pat, shreg_q;
  logic [LEN_W-1:0] sel_raw, sel_len, len_q, bit_cnt_q;
  logic [DIV_W-1:0] div_cnt_q;
  logic [GAP_W-1:0] gap_cnt_q;
  logic             signal_q, signal_d;
  logic             arb_en, start, bit_end, last_bit, gap_end;

  // Handshake: req[i] is a level held until done[i]; done[i] is a one-clock pulse in IDLE, and
  // a req still high in that cycle is not considered until the following clock.
  assign arb_en = (state_q == ST_IDLE) && (done_q == '0);

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req    (req),
    .ptr    (rr_ptr_q),
    .enable (arb_en),
    .gnt    (arb_gnt)
  );

  always_comb begin
    arb_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (arb_gnt[i]) arb_idx = PTR_W'(i);
    end
  end

  assign start    = arb_en && (arb_gnt != '0);
  assign sel_pat  = pattern[win_q*PAT_W +: PAT_W];
  assign sel_raw  = length[win_q*LEN_W +: LEN_W];
  assign sel_len  = (sel_raw > LEN_MAX) ? LEN_MAX : sel_raw;
  assign bit_end  = (state_q == ST_RUN) && (div_cnt_q == DIV_LAST);
  assign last_bit = bit_end && (bit_cnt_q == len_q - LEN_W'(1));
  assign gap_end  = (state_q == ST_GAP) && (gap_cnt_q == GAP_LAST);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_LOAD;
      ST_LOAD: state_d = (sel_len == '0) ? ST_GAP : ST_RUN;
      ST_RUN:  if (last_bit) state_d = ST_GAP;
      ST_GAP:  if (gap_end) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs; signal only ever comes from a flop.
  always_comb begin
    grant_d  = grant_q;
    done_d   = '0;
    signal_d = 1'b0;
    case (state_q)
      ST_IDLE: if (start) grant_d = arb_gnt;
      ST_LOAD: signal_d = (sel_len != '0) && sel_pat[0];
      ST_RUN:  signal_d = bit_end ? (!last_bit && shreg_q[0]) : signal_q;
      ST_GAP: begin
        if (gap_end) begin
          grant_d = '0;
          done_d  = grant_q;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      grant_q   <= '0;
      done_q    <= '0;
      signal_q  <= 1'b0;
      win_q     <= '0;
      rr_ptr_q  <= '0;
      shreg_q   <= '0;
      len_q     <= '0;
      bit_cnt_q <= '0;
      div_cnt_q <= '0;
      gap_cnt_q <= '0;
    end else begin
      grant_q  <= grant_d;
      done_q   <= done_d;
      signal_q <= signal_d;
      case (state_q)
        ST_IDLE: if (start) win_q <= arb_idx;
        ST_LOAD: begin
          // Bit 0 goes straight to signal, so the shifter holds only the remaining bits.
          shreg_q   <= sel_pat >> 1;
          len_q     <= sel_len;
          bit_cnt_q <= '0;
          div_cnt_q <= '0;
          gap_cnt_q <= '0;
        end
        ST_RUN: begin
          if (bit_end) begin
            div_cnt_q <= '0;
            shreg_q   <= shreg_q >> 1;
            bit_cnt_q <= bit_cnt_q + LEN_W'(1);
          end else begin
            div_cnt_q <= div_cnt_q + DIV_W'(1);
          end
        end
        ST_GAP: begin
          gap_cnt_q <= gap_cnt_q + GAP_W'(1);
          if (gap_end) rr_ptr_q <= (win_q == PTR_LAST) ? '0 : win_q + PTR_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign grant     = grant_q;
  assign done      = done_q;
  assign signal    = signal_q;
  assign busy      = (state_q != ST_IDLE);
  assign fsm_state = state_q;

endmodule

// File: tb/tb_pulse_burst_scheduler.sv
// Bench for pulse_burst_scheduler: directed bursts plus random traffic against a burst-level model.
module tb_pulse_burst_scheduler;
  import pulse_pkg::*;

  localparam int NREQ  = 2;
  localparam int PAT_W = 12;
  localparam int LEN_W = 4;
  localparam int DIV   = 4;
  localparam int GAP   = 2;

  logic                  clock;
  logic                  reset;
  logic [NREQ-1:0]       req;
  logic [NREQ*PAT_W-1:0] pattern;
  logic [NREQ*LEN_W-1:0] length;
  logic [NREQ-1:0]       grant;
  logic [NREQ-1:0]       done;
  logic                  signal;
  logic                  busy;
  state_t                fsm_state;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 0;

  pulse_burst_scheduler #(
    .NREQ(NREQ), .PAT_W(PAT_W), .LEN_W(LEN_W), .DIV(DIV), .GAP(GAP)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .req       (req),
    .pattern   (pattern),
    .length    (length),
    .grant     (grant),
    .done      (done),
    .signal    (signal),
    .busy      (busy),
    .fsm_state (fsm_state)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- reference model ----------------
  // A burst is tracked by its age m_t in clocks since grant rose (-1 when idle).
  int                m_t   = -1;
  int                m_win = 0;
  int                m_ptr = 0;
  int                m_len = 0;
  bit                m_blk = 0;
  logic [PAT_W-1:0]  m_pat = '0;
  logic [NREQ-1:0]   exp_grant = '0;
  logic [NREQ-1:0]   exp_done  = '0;
  logic              exp_signal = 1'b0;
  logic              exp_busy   = 1'b0;
  logic [NREQ-1:0]   exp_q[$];
  logic [NREQ-1:0]   pending = '0;

  always @(posedge clock or negedge reset) begin
    exp_done = '0;
    if (!reset) begin
      m_t   = -1;
      m_ptr = 0;
      m_blk = 0;
      exp_q.delete();
    end else if (m_t >= 0) begin
      if (m_t == 0) begin
        m_pat = pattern[m_win*PAT_W +: PAT_W];
        m_len = int'(length[m_win*LEN_W +: LEN_W]);
        if (m_len > PAT_W) m_len = PAT_W;
      end
      m_t++;
      if (m_t == 1 + m_len*DIV + GAP) begin
        exp_done = NREQ'(1) << m_win;
        exp_q.push_back(NREQ'(1) << m_win);
        m_ptr = (m_win + 1) % NREQ;
        m_t   = -1;
        m_blk = 1;
      end
    end else if (m_blk) begin
      m_blk = 0;
    end else if (req != '0) begin
      for (int k = NREQ - 1; k >= 0; k--)
        if (req[(m_ptr + k) % NREQ]) m_win = (m_ptr + k) % NREQ;
      m_t = 0;
    end
    exp_busy   = (m_t >= 0);
    exp_grant  = (m_t >= 0) ? (NREQ'(1) << m_win) : '0;
    exp_signal = (m_t >= 1 && m_t <= m_len*DIV) ? m_pat[(m_t-1)/DIV] : 1'b0;
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    if (reset && chk_en) begin
      check("grant", grant, exp_grant);
      check("done", done, exp_done);
      check("signal", signal, exp_signal);
      check("busy", busy, exp_busy);
      check("state_idle", fsm_state == ST_IDLE, m_t < 0);
      if (done != '0) begin
        if (exp_q.size() == 0) check("done_unexpected", done, 0);
        else                   check("done_who", done, exp_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_out(input bit want_done, input logic [NREQ-1:0] mask, output int n);
    bit hit;
    n   = 0;
    hit = 0;
    while (!hit && n < 300) begin
      @(negedge clock);
      n++;
      hit = (((want_done ? done : grant) & mask) != '0);
    end
    if (!hit) begin
      if (want_done) check("timeout_done", 0, 1);
      else           check("timeout_grant", 0, 1);
      n = -1;
    end
  endtask

  task automatic run_burst(input int i, input logic [PAT_W-1:0] pat, input logic [LEN_W-1:0] len,
                           input int exp_lat);
    int n;
    @(negedge clock);
    pattern[i*PAT_W +: PAT_W] = pat;
    length[i*LEN_W +: LEN_W]  = len;
    req[i] = 1'b1;
    wait_out(0, NREQ'(1) << i, n);
    wait_out(1, NREQ'(1) << i, n);
    check("latency", n, exp_lat);
    req[i] = 1'b0;
  endtask

  task automatic new_req(input int i);
    pattern[i*PAT_W +: PAT_W] = PAT_W'($urandom);
    length[i*LEN_W +: LEN_W]  = LEN_W'($urandom_range(0, 15));
    req[i]     = 1'b1;
    pending[i] = 1'b1;
  endtask

  task automatic drive_random(input bit allow_new);
    for (int i = 0; i < NREQ; i++) begin
      if (exp_done[i]) begin
        if (allow_new && $urandom_range(0, 1) == 1) new_req(i);
        else begin
          req[i]     = 1'b0;
          pending[i] = 1'b0;
        end
      end else if (!req[i] && !pending[i]) begin
        if (allow_new && $urandom_range(0, 3) == 0) new_req(i);
      end else if (m_t >= 1 && m_win == i) begin
        // Inputs of the requester being served must be ignored after capture.
        pattern[i*PAT_W +: PAT_W] = PAT_W'($urandom);
        length[i*LEN_W +: LEN_W]  = LEN_W'($urandom_range(0, 15));
        if (req[i] && $urandom_range(0, 15) == 0) req[i] = 1'b0;
      end
    end
  endtask

  // ---------------- stimulus ----------------
  logic [NREQ-1:0] alt [4];
  int n;
  int w;

  initial begin
    alt[0] = 2'b01; alt[1] = 2'b10; alt[2] = 2'b01; alt[3] = 2'b10;
    req = '0; pattern = '0; length = '0;
    reset = 1'b1;
    #1 reset = 1'b0;

    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check("rst_grant", grant, 0);
      check("rst_done", done, 0);
      check("rst_signal", signal, 0);
      check("rst_busy", busy, 0);
    end
    @(negedge clock);
    reset  = 1'b1;
    chk_en = 1'b1;

    // Both requesting with equal lengths: service must alternate starting at requester 0.
    @(negedge clock);
    pattern = {PAT_W'($urandom), PAT_W'($urandom)};
    length  = {LEN_W'(3), LEN_W'(3)};
    req     = 2'b11;
    for (int k = 0; k < 4; k++) begin
      wait_out(0, 2'b11, n);
      check("alt_grant", grant, alt[k]);
      wait_out(1, 2'b11, n);
      check("alt_done", done, alt[k]);
    end
    req = '0;

    run_burst(0, 12'b0000_0010_1101, 4'd6, 1 + 6*DIV + GAP);
    run_burst(0, PAT_W'($urandom), 4'd0, 1 + GAP);
    run_burst(0, PAT_W'($urandom), 4'd15, 1 + PAT_W*DIV + GAP);
    run_burst(1, PAT_W'($urandom), 4'd1, 1 + DIV + GAP);

    // Requester drops req five clocks into RUN; the burst must still finish.
    @(negedge clock);
    pattern[0 +: PAT_W] = PAT_W'($urandom);
    length[0 +: LEN_W]  = 4'd8;
    req[0] = 1'b1;
    wait_out(0, 2'b01, n);
    repeat (6) @(negedge clock);
    req[0] = 1'b0;
    wait_out(1, 2'b01, n);
    check("drop_latency", n + 6, 1 + 8*DIV + GAP);

    // Reset in the middle of an all-ones burst.
    @(negedge clock);
    pattern[PAT_W +: PAT_W] = '1;
    length[LEN_W +: LEN_W]  = 4'd10;
    req[1] = 1'b1;
    wait_out(0, 2'b10, n);
    repeat (10) @(negedge clock);
    check("pre_rst_signal", signal, 1);
    #2 reset = 1'b0;
    #1;
    check("mid_rst_grant", grant, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_signal", signal, 0);
    check("mid_rst_busy", busy, 0);
    req = '0;
    repeat (3) begin
      @(negedge clock);
      check("rst_hold_done", done, 0);
      check("rst_hold_busy", busy, 0);
    end
    reset = 1'b1;

    // Random traffic, then let outstanding requests drain.
    pending = '0;
    repeat (3000) begin
      @(negedge clock);
      drive_random(1);
    end
    w = 0;
    while ((pending != '0 || m_t >= 0) && w < 1500) begin
      @(negedge clock);
      drive_random(0);
      w++;
    end
    repeat (2) @(negedge clock);
    check("done_queue_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
